fwd_scoreboard: RTL and testbench

- Parametrised successor to the pipeline forwarding logic; it sits alongside the EX stage.
- Owns an internal DEPTH-entry shift register of in-flight writers (EX/MEM, MEM/WB, WB, ...), each entry holding destination tag and result data.
- Resolves bypass data for NUM_RD_PORTS EX-stage source operands with youngest-wins priority.
- Raises a load-use hazard when the matching producer is a load whose data is not yet available, and counts hazard cycles.

---
 rtl/fwd_scoreboard_pkg.sv | 23 ++
 rtl/fwd_scoreboard_match.sv | 33 +++
 rtl/fwd_scoreboard.sv | 106 ++++++++++
 tb/tb_fwd_scoreboard.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: the in-flight writer entry
// and the tag-match helper used by every read-port encoder.
package fwd_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [REG_AW-1:0] rd;
      logic              rdy;
      logic [XLEN-1:0]   data;
   } entry_t;

   // x0 is hard-wired, so a writer targeting it must never be seen as a producer
   function automatic logic entry_hit(input entry_t e, input logic [REG_AW-1:0] rs);
      return e.valid & e.we & (e.rd == rs) & (rs != REG_ZERO);
   endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// Per-port priority encoder: finds the youngest in-flight writer of one
// source register and reports whether it was found, its readiness and data.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  entry_t [DEPTH-1:0] i_entries,
   input  logic [REG_AW-1:0]  i_rs,
   output logic               o_hit,
   output logic               o_rdy,
   output logic [XLEN-1:0]    o_data
);

   // scan oldest to youngest so the lowest index overwrites and wins
   always_comb begin
      o_hit  = 1'b0;
      o_rdy  = 1'b0;
      o_data = {XLEN{1'b0}};
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (entry_hit(i_entries[k], i_rs)) begin
            o_hit  = 1'b1;
            o_rdy  = i_entries[k].rdy;
            o_data = i_entries[k].data;
         end else begin
            o_hit  = o_hit;
            o_rdy  = o_rdy;
            o_data = o_data;
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX-stage bypass scoreboard: tracks DEPTH in-flight writers, resolves
// youngest-wins forwarding per source port and flags load-use hazards.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int XLEN         = fwd_pkg::XLEN,
   parameter int REG_AW       = fwd_pkg::REG_AW,
   parameter int NUM_RD_PORTS = 2,
   parameter int DEPTH        = 3,
   parameter int CNT_W        = 16
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_hold,
   input  logic                           i_flush,
   input  logic                           i_ex_valid,
   input  logic                           i_ex_we,
   input  logic                           i_ex_is_load,
   input  logic [REG_AW-1:0]              i_ex_rd,
   input  logic [XLEN-1:0]                i_ex_result,
   input  logic [NUM_RD_PORTS*REG_AW-1:0] i_ex_rs,
   input  logic [XLEN-1:0]                i_mem_rdata,
   output logic [NUM_RD_PORTS-1:0]        o_fwd_valid,
   output logic [NUM_RD_PORTS*XLEN-1:0]   o_fwd_data,
   output logic                           o_hazard_stall,
   output logic [CNT_W-1:0]               o_hazard_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   entry_t [DEPTH-1:0]           r_entries;
   entry_t                       w_new_entry;
   entry_t                       w_aged_entry;
   logic [NUM_RD_PORTS-1:0]      w_hit;
   logic [NUM_RD_PORTS-1:0]      w_rdy;
   logic [NUM_RD_PORTS-1:0]      w_need_stall;
   logic [NUM_RD_PORTS*XLEN-1:0] w_match_data;
   logic                         w_hazard;
   logic [CNT_W-1:0]             r_hazard_cnt;

   for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_port
      fwd_match #(
         .DEPTH(DEPTH)
      ) u_match (
         .i_entries(r_entries),
         .i_rs     (i_ex_rs[g*REG_AW +: REG_AW]),
         .o_hit    (w_hit[g]),
         .o_rdy    (w_rdy[g]),
         .o_data   (w_match_data[g*XLEN +: XLEN])
      );

      assign o_fwd_valid[g]             = w_hit[g] & w_rdy[g];
      assign o_fwd_data[g*XLEN +: XLEN] = (w_hit[g] & w_rdy[g]) ? w_match_data[g*XLEN +: XLEN]
                                                                : {XLEN{1'b0}};
      assign w_need_stall[g]            = w_hit[g] & ~w_rdy[g];
   end

   assign w_hazard       = i_ex_valid & (|w_need_stall);
   assign o_hazard_stall = w_hazard;
   assign o_hazard_cnt   = r_hazard_cnt;

   // a stalled or flushed EX instruction enters the pipe as a bubble
   always_comb begin
      w_new_entry.valid = i_ex_valid & ~i_flush & ~w_hazard;
      w_new_entry.we    = i_ex_we;
      w_new_entry.rd    = i_ex_rd;
      w_new_entry.rdy   = ~i_ex_is_load;
      w_new_entry.data  = i_ex_result;
   end

   // a load leaving entry 0 picks up its memory data, which makes it ready
   always_comb begin
      w_aged_entry = r_entries[0];
      if (!r_entries[0].rdy) begin
         w_aged_entry.rdy  = 1'b1;
         w_aged_entry.data = i_mem_rdata;
      end else begin
         w_aged_entry.rdy  = r_entries[0].rdy;
         w_aged_entry.data = r_entries[0].data;
      end
   end

   // writer shift register; hold freezes everything, including flush
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_entries <= '0;
      end else if (!i_hold) begin
         r_entries[0] <= w_new_entry;
         r_entries[1] <= w_aged_entry;
         for (int k = 2; k < DEPTH; k++) begin
            r_entries[k] <= r_entries[k-1];
         end
      end
   end

   // saturating count of cycles that actually stalled the pipe
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hazard_cnt <= {CNT_W{1'b0}};
      end else if (w_hazard && !i_hold && (r_hazard_cnt != CNT_MAX)) begin
         r_hazard_cnt <= r_hazard_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (DEPTH=3, two read ports, 2-bit counter
// so saturation is reachable); expected values are worked out by hand.
module tb_fwd_scoreboard;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NP     = 2;
   localparam int CNT_W  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 hold;
   logic                 flush;
   logic                 ex_valid;
   logic                 ex_we;
   logic                 ex_is_load;
   logic [REG_AW-1:0]    ex_rd;
   logic [XLEN-1:0]      ex_result;
   logic [NP*REG_AW-1:0] ex_rs;
   logic [XLEN-1:0]      mem_rdata;
   logic [NP-1:0]        fwd_valid;
   logic [NP*XLEN-1:0]   fwd_data;
   logic                 hazard_stall;
   logic [CNT_W-1:0]     hazard_cnt;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   fwd_scoreboard #(
      .XLEN(XLEN), .REG_AW(REG_AW), .NUM_RD_PORTS(NP), .DEPTH(3), .CNT_W(CNT_W)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_hold        (hold),
      .i_flush       (flush),
      .i_ex_valid    (ex_valid),
      .i_ex_we       (ex_we),
      .i_ex_is_load  (ex_is_load),
      .i_ex_rd       (ex_rd),
      .i_ex_result   (ex_result),
      .i_ex_rs       (ex_rs),
      .i_mem_rdata   (mem_rdata),
      .o_fwd_valid   (fwd_valid),
      .o_fwd_data    (fwd_data),
      .o_hazard_stall(hazard_stall),
      .o_hazard_cnt  (hazard_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drive one EX instruction; outputs settle 1ns later
   task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                        input logic [31:0] res, input logic [4:0] rs1, input logic [4:0] rs0);
      ex_valid   = v;
      ex_we      = we;
      ex_is_load = ld;
      ex_rd      = rd;
      ex_result  = res;
      ex_rs      = {rs1, rs0};
      #1;
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; flush = 1'b0; mem_rdata = 32'h0;
      ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0;
      ex_rd = 5'd0; ex_result = 32'h0; ex_rs = 10'd0;
      repeat (2) step();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      chk("rst_valid", 64'(fwd_valid), 64'h0);
      chk("rst_data", fwd_data, 64'h0);
      chk("rst_stall", 64'(hazard_stall), 64'h0);
      chk("rst_cnt", 64'(hazard_cnt), 64'h0);
      rst = 1'b0;

      // back-to-back ALU
      drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 5'd0, 5'd0);
      step();
      drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h0606, 5'd5, 5'd5);
      chk("b2b_valid", 64'(fwd_valid), 64'h3);
      chk("b2b_data", fwd_data, 64'h0000_1234_0000_1234);
      chk("b2b_stall", 64'(hazard_stall), 64'h0);

      // youngest wins; second port resolves to an older entry independently
      step();
      drive(1'b1, 1'b1, 1'b0, 5'd7, 32'hAAAA, 5'd0, 5'd0);
      step();
      drive(1'b1, 1'b1, 1'b0, 5'd7, 32'hBBBB, 5'd0, 5'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd7);
      chk("prio_valid", 64'(fwd_valid), 64'h3);
      chk("prio_data", fwd_data, 64'h0000_0606_0000_BBBB);

      // x0 is never forwarded
      step();
      drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF, 5'd0, 5'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      chk("x0_valid", 64'(fwd_valid), 64'h0);
      chk("x0_data", fwd_data, 64'h0);

      // load-use hazard, held for 3 cycles, then resolved from memory data
      step();
      drive(1'b1, 1'b1, 1'b1, 5'd8, 32'h1111, 5'd0, 5'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
      chk("lu_stall", 64'(hazard_stall), 64'h1);
      chk("lu_valid", 64'(fwd_valid), 64'h0);
      chk("lu_cnt0", 64'(hazard_cnt), 64'h0);
      hold = 1'b1;
      mem_rdata = 32'hDEAD;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("hold_stall", 64'(hazard_stall), 64'h1);
         chk("hold_valid", 64'(fwd_valid), 64'h0);
         chk("hold_cnt", 64'(hazard_cnt), 64'h0);
      end
      hold = 1'b0;
      step();
      chk("lu_clear", 64'(hazard_stall), 64'h0);
      chk("lu_fvalid", 64'(fwd_valid), 64'h1);
      chk("lu_fdata", fwd_data, 64'h0000_0000_0000_DEAD);
      chk("lu_cnt1", 64'(hazard_cnt), 64'h1);

      // flushed producer leaves a bubble; x8 still visible in entry 2
      flush = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h9999, 5'd0, 5'd0);
      step();
      flush = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
      chk("flush_valid", 64'(fwd_valid), 64'h2);
      chk("flush_data", fwd_data, 64'h0000_DEAD_0000_0000);
      chk("flush_stall", 64'(hazard_stall), 64'h0);

      // retirement: visible through entry 2, gone after DEPTH+1 advances
      drive(1'b1, 1'b1, 1'b0, 5'd10, 32'hA0A0, 5'd0, 5'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd10);
      step();
      step();
      chk("ret_e2_valid", 64'(fwd_valid), 64'h1);
      chk("ret_e2_data", fwd_data, 64'h0000_0000_0000_A0A0);
      step();
      chk("ret_gone", 64'(fwd_valid), 64'h0);

      // counter saturates at 3 with CNT_W=2
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 1'b1, 1'b1, 5'd11, 32'h0, 5'd0, 5'd0);
         step();
         drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd0);
         chk("sat_stall", 64'(hazard_stall), 64'h1);
         step();
         chk("sat_cnt", 64'(hazard_cnt), (p == 0) ? 64'h2 : 64'h3);
      end

      // async reset between edges while a hazard is raised
      drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h0, 5'd0, 5'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd12);
      chk("ar_pre_stall", 64'(hazard_stall), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_stall", 64'(hazard_stall), 64'h0);
      chk("ar_valid", 64'(fwd_valid), 64'h0);
      chk("ar_data", fwd_data, 64'h0);
      chk("ar_cnt", 64'(hazard_cnt), 64'h0);
      #1;
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
